// File: rtl/io_tx_buffer_if.sv
// io_tx_buffer_if: CPU write bus plus UART byte stream seen by io_tx_buffer.
// master = CPU/UART side driving the buffer, slave = the buffer itself.
interface io_tx_buffer_if;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output rdy_in,
        output mem_a,
        output mem_dout,
        output mem_wr,
        output tx_ready,
        input  io_buffer_full,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rdy_in,
        input  mem_a,
        input  mem_dout,
        input  mem_wr,
        input  tx_ready,
        output io_buffer_full,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/io_tx_buffer.sv
// io_tx_buffer: byte transmit FIFO between the CPU I/O window and the UART.
// Data writes to offset 0 queue non-NUL bytes; a write to offset 4 drains the
// FIFO, sends a terminating NUL and halts until reset.
// Optional feature macro: IO_TX_STATS_EN (enables the tx_count byte counter).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | normal operation, CPU data writes are queued
// DRAIN     | stop requested, FIFO emptying, new writes ignored
// SEND_NUL  | FIFO empty, presenting 0x00 to the UART
// HALTED    | NUL accepted, prog_stop high, only reset leaves
//
// DEPTH must be a power of two and at least 4; FULL_MARGIN below DEPTH.
module io_tx_buffer #(
    parameter int DEPTH       = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    io_tx_buffer_if.slave   bus,
    output logic            prog_stop,
    output logic            overflow,
    output logic [31:0]     tx_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] MARGIN_V = (ADDR_W + 1)'(FULL_MARGIN);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_SEND_NUL = 2'd2;
    localparam logic [1:0] ST_HALTED   = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] wr_ptr_nxt;
    logic [ADDR_W:0] rd_ptr_nxt;
    logic [ADDR_W:0] count_nxt;
    logic [ADDR_W:0] free_nxt;
    logic [7:0]      fifo_mem [DEPTH];

    logic empty;
    logic full;
    logic io_wr;
    logic data_wr;
    logic stop_wr;
    logic drain_phase;
    logic fifo_pop;
    logic push_ok;
    logic drop;
    logic nul_done;
    logic buf_full_r;
    logic buf_full_nxt;
    logic unused_addr;

    // Only the window select and the offset bits take part in decode.
    assign unused_addr = ^{bus.mem_a[31:18], bus.mem_a[15:3]};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    assign io_wr   = bus.rdy_in && bus.mem_wr && (bus.mem_a[17:16] == 2'b11);
    assign data_wr = io_wr && (bus.mem_a[2:0] == 3'd0) &&
                     (bus.mem_dout != 8'h00) && (state == ST_RUN);
    assign stop_wr = io_wr && (bus.mem_a[2:0] == 3'd4) && (state == ST_RUN);

    // FIFO head is presented to the UART only while the queue is live.
    assign drain_phase = (state == ST_RUN) || (state == ST_DRAIN);
    assign fifo_pop    = drain_phase && !empty && bus.tx_ready;
    assign nul_done    = (state == ST_SEND_NUL) && bus.tx_ready;

    // A push into a full FIFO still fits if the head leaves in the same cycle.
    assign push_ok = data_wr && (!full || fifo_pop);
    assign drop    = data_wr && full && !fifo_pop;

    // Next pointer values, shared by the pointer registers and the full flag.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (push_ok) begin
            wr_ptr_nxt = wr_ptr + 1'b1;
        end
        if (fifo_pop) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
        end
    end

    // Stop sequencing: drain, send NUL, halt.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (stop_wr) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (empty) begin
                    state_nxt = ST_SEND_NUL;
                end
            end
            ST_SEND_NUL: begin
                if (bus.tx_ready) begin
                    state_nxt = ST_HALTED;
                end
            end
            default: state_nxt = ST_HALTED;
        endcase
    end

    // Back-pressure from the post-edge occupancy so it is a clean register.
    always_comb begin
        count_nxt    = wr_ptr_nxt - rd_ptr_nxt;
        free_nxt     = DEPTH_V - count_nxt;
        buf_full_nxt = (free_nxt <= MARGIN_V) || (state_nxt != ST_RUN);
    end

    // Control state, pointers and sticky status flags.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= ST_RUN;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            buf_full_r <= 1'b0;
            overflow   <= 1'b0;
            prog_stop  <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            buf_full_r <= buf_full_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (nul_done) begin
                prog_stop <= 1'b1;
            end
        end
    end

    // Byte storage; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            fifo_mem[wr_ptr[ADDR_W-1:0]] <= bus.mem_dout;
        end
    end

    assign bus.tx_valid       = (drain_phase && !empty) || (state == ST_SEND_NUL);
    assign bus.tx_data        = (drain_phase && !empty) ? fifo_mem[rd_ptr[ADDR_W-1:0]] : 8'h00;
    assign bus.io_buffer_full = buf_full_r;

`ifdef IO_TX_STATS_EN
    logic [31:0] tx_count_r;

    // Count every byte the UART takes, the closing NUL included.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_count_r <= 32'h0;
        end else if (fifo_pop || nul_done) begin
            tx_count_r <= tx_count_r + 32'd1;
        end
    end

    assign tx_count = tx_count_r;
`else
    assign tx_count = 32'h0;
`endif

endmodule

// File: tb/tb_io_tx_buffer.sv
// tb_io_tx_buffer: directed checks of io_tx_buffer with hand-computed results.
module tb_io_tx_buffer;

    logic        clk_in;
    logic        rst_in;
    logic        prog_stop;
    logic        overflow;
    logic [31:0] tx_count;

    int n_checks;
    int n_errors;

    io_tx_buffer_if bus ();

    io_tx_buffer #(
        .DEPTH       (16),
        .FULL_MARGIN (2)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .bus       (bus.slave),
        .prog_stop (prog_stop),
        .overflow  (overflow),
        .tx_count  (tx_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef IO_TX_STATS_EN
        return 32'(n);
`else
        return (n > 0) ? 32'h0 : 32'h0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus_set(input logic rdy, input logic wr, input logic [31:0] a, input logic [7:0] d);
        bus.rdy_in   = rdy;
        bus.mem_wr   = wr;
        bus.mem_a    = a;
        bus.mem_dout = d;
    endtask

    task automatic bus_idle();
        bus_set(1'b1, 1'b0, 32'h0, 8'h00);
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
        bus_set(1'b1, 1'b1, a, d);
        tick();
        bus_idle();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_in      = 1'b0;
        bus.tx_ready = 1'b0;
        bus_idle();

        // reset state
        #3;
        check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h0);
        check("rst_full", 32'(bus.io_buffer_full), 32'h0);
        check("rst_prog_stop", 32'(prog_stop), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_tx_count", tx_count, 32'h0);
        #10;
        rst_in = 1'b1;
        tick();

        // two bytes back to back with the UART always ready
        bus.tx_ready = 1'b1;
        bus_set(1'b1, 1'b1, 32'h0003_0000, 8'h41);
        tick();
        check("b41_valid", 32'(bus.tx_valid), 32'h1);
        check("b41_data", 32'(bus.tx_data), 32'h41);
        bus_set(1'b1, 1'b1, 32'h0003_0000, 8'h42);
        tick();
        check("b42_valid", 32'(bus.tx_valid), 32'h1);
        check("b42_data", 32'(bus.tx_data), 32'h42);
        bus_idle();
        tick();
        check("pair_done_valid", 32'(bus.tx_valid), 32'h0);
        check("pair_tx_count", tx_count, exp_cnt(2));

        // NUL data write is dropped silently
        cpu_write(32'h0003_0000, 8'h00);
        check("nul_wr_valid", 32'(bus.tx_valid), 32'h0);
        tick();
        check("nul_wr_count", tx_count, exp_cnt(2));

        // fill with UART stalled: threshold, last slots, overflow
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            cpu_write(32'h0003_0000, 8'(8'h80 + i));
            check($sformatf("fill_full_%0d", i), 32'(bus.io_buffer_full), (i >= 14) ? 32'h1 : 32'h0);
        end
        cpu_write(32'h0003_0000, 8'h8F);
        cpu_write(32'h0003_0000, 8'h90);
        check("fill16_overflow", 32'(overflow), 32'h0);
        cpu_write(32'h0003_0000, 8'hEE);
        check("fill17_overflow", 32'(overflow), 32'h1);
        bus.tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("drain_valid_%0d", i), 32'(bus.tx_valid), 32'h1);
            check($sformatf("drain_data_%0d", i), 32'(bus.tx_data), 32'(8'h80 + i));
            tick();
        end
        check("drain_end_valid", 32'(bus.tx_valid), 32'h0);
        check("drain_end_full", 32'(bus.io_buffer_full), 32'h0);
        check("drain_tx_count", tx_count, exp_cnt(18));

        // stop sequence
        bus.tx_ready = 1'b0;
        cpu_write(32'h0003_0000, 8'h61);
        cpu_write(32'h0003_0000, 8'h62);
        check("stop_pre_full", 32'(bus.io_buffer_full), 32'h0);
        cpu_write(32'h0003_0004, 8'h55);
        check("stop_drain_full", 32'(bus.io_buffer_full), 32'h1);
        tick();
        tick();
        tick();
        check("stop_hold_valid", 32'(bus.tx_valid), 32'h1);
        check("stop_hold_data", 32'(bus.tx_data), 32'h61);
        bus.tx_ready = 1'b1;
        check("stop_b61", 32'(bus.tx_data), 32'h61);
        tick();
        check("stop_b62", 32'(bus.tx_data), 32'h62);
        tick();
        check("stop_gap_valid", 32'(bus.tx_valid), 32'h0);
        tick();
        check("stop_nul_valid", 32'(bus.tx_valid), 32'h1);
        check("stop_nul_data", 32'(bus.tx_data), 32'h0);
        check("stop_nul_prog_stop", 32'(prog_stop), 32'h0);
        tick();
        check("halt_prog_stop", 32'(prog_stop), 32'h1);
        check("halt_valid", 32'(bus.tx_valid), 32'h0);
        check("halt_tx_count", tx_count, exp_cnt(21));
        cpu_write(32'h0003_0000, 8'h63);
        check("halt_wr_valid", 32'(bus.tx_valid), 32'h0);
        tick();
        check("halt_wr_valid2", 32'(bus.tx_valid), 32'h0);
        check("halt_full", 32'(bus.io_buffer_full), 32'h1);

        // reset out of HALTED, then again while sending the NUL
        rst_in = 1'b0;
        #2;
        check("rst_halt_prog_stop", 32'(prog_stop), 32'h0);
        rst_in = 1'b1;
        bus.tx_ready = 1'b0;
        cpu_write(32'h0003_0004, 8'h00);
        tick();
        check("sn_valid", 32'(bus.tx_valid), 32'h1);
        check("sn_data", 32'(bus.tx_data), 32'h0);
        rst_in = 1'b0;
        #2;
        check("sn_rst_valid", 32'(bus.tx_valid), 32'h0);
        check("sn_rst_prog_stop", 32'(prog_stop), 32'h0);
        check("sn_rst_full", 32'(bus.io_buffer_full), 32'h0);
        rst_in = 1'b1;
        bus.tx_ready = 1'b1;
        cpu_write(32'h0003_0000, 8'h5A);
        check("post_rst_valid", 32'(bus.tx_valid), 32'h1);
        check("post_rst_data", 32'(bus.tx_data), 32'h5A);
        tick();
        check("post_rst_done", 32'(bus.tx_valid), 32'h0);
        check("post_rst_count", tx_count, exp_cnt(1));

        // rdy_in low blocks the write but not the drain
        bus.tx_ready = 1'b0;
        cpu_write(32'h0003_0000, 8'h77);
        check("rdy_q_data", 32'(bus.tx_data), 32'h77);
        bus_set(1'b0, 1'b1, 32'h0003_0000, 8'h33);
        bus.tx_ready = 1'b1;
        tick();
        check("rdy_low_valid", 32'(bus.tx_valid), 32'h0);
        bus_idle();
        tick();
        check("rdy_low_valid2", 32'(bus.tx_valid), 32'h0);
        check("rdy_low_count", tx_count, exp_cnt(2));
        check("rdy_low_overflow", 32'(overflow), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/io_tx_buffer.md
# io_tx_buffer

Byte-wide transmit buffer between the CPU memory bus and the UART transmitter. It captures CPU writes to the I/O window, queues output bytes in a FIFO, and drives `io_buffer_full` back to the CPU. It turns the 0x30004 program-stop write into a drained, NUL-terminated shutdown sequence. It sits directly downstream of the CPU's `mem_a`/`mem_dout`/`mem_wr` bus, alongside the RAM.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 4.
- `FULL_MARGIN`, 2: free-slot slack; `io_buffer_full` rises while free slots ≤ this value, so in-flight CPU writes still fit.
- `clk_in` in 1: system clock, rising-edge.
- `rst_in` in 1: one clock; reset is asynchronous and active-low. All state clears immediately when low.
- `rdy_in` in 1: bus qualifier; CPU-side captures happen only when high.
- `mem_a` in 32: CPU address bus.
- `mem_dout` in 8: CPU write data.
- `mem_wr` in 1: 1 = write.
- `io_buffer_full` out 1: back-pressure to the CPU.
- `tx_data` out 8: byte to the UART.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: UART accepts the byte this cycle.
- `prog_stop` out 1: sticky; the stop sequence has completed.
- `overflow` out 1: sticky; a byte was dropped because the FIFO was full.
- `tx_count` out 32: count of bytes accepted by the UART (see Configuration).

## Operation
- I/O write: `rdy_in & mem_wr & (mem_a[17:16]==2'b11)`.
- Data write, `mem_a[2:0]==0`:
  - Nonzero `mem_dout` is pushed.
  - 0x00 is ignored.
- Stop write, `mem_a[2:0]==4`: stop request. Data is ignored.
- Any other I/O offset is ignored.
- FIFO: circular buffer with `log2(DEPTH)+1`-bit read/write pointers.
  - Wrap-around uses the low bits of each pointer.
  - Full = MSBs differ and low bits equal. Empty = pointers equal.
- Push when full:
  - If a pop occurs in the same cycle, the push succeeds and count is unchanged.
  - Otherwise the byte is dropped and `overflow` is set.
- Pop: `tx_valid & tx_ready`. The pop side is independent of `rdy_in`.
- State machine:
  - RUN: normal operation. A stop write moves to DRAIN. A data write in the same cycle as the stop write is impossible (single bus).
  - DRAIN: data writes are still ignored. When the FIFO is empty and no pop is pending, go to SEND_NUL.
  - SEND_NUL: `tx_data`=0x00, `tx_valid`=1. On `tx_ready`, go to HALTED.
  - HALTED: `prog_stop`=1, `tx_valid`=0, all writes ignored. Only reset leaves this state.
- `tx_valid` in RUN/DRAIN equals !empty. `tx_data` is the head entry.
- `tx_data` must be stable while `tx_valid & !tx_ready`.
- `io_buffer_full` = (DEPTH − count) ≤ `FULL_MARGIN`, or state ≠ RUN.

## Timing
- Reset values:
  - `tx_valid`, `io_buffer_full`, `prog_stop`, `overflow`: 0.
  - `tx_data`: 0x00.
  - `tx_count`: 0.
  - State: RUN; pointers: 0.
- A write captured at edge N is visible on `tx_valid`/`tx_data` after edge N (registered), when the FIFO was empty. There is no combinational path from `mem_*` to `tx_*`.
- `io_buffer_full` is registered from post-edge count: it rises the cycle after the push that crosses the threshold, and falls the cycle after the pop that uncrosses it.
- Throughput: one push and one pop per cycle.
- DRAIN→SEND_NUL takes 1 cycle after the last pop. SEND_NUL→HALTED takes 1 cycle after the handshake. `prog_stop` rises at that edge.
- `rdy_in` low: pushes are suppressed, pops continue.
- Reset asserted mid-sequence (any state) returns to RUN with an empty FIFO asynchronously. The in-flight byte is lost.

## Configuration
- `IO_TX_STATS_EN` defined: `tx_count` increments on every completed pop, including the final NUL. It wraps at 2^32.
- `IO_TX_STATS_EN` undefined: `tx_count` is tied to 32'h0 and the counter logic is absent.

## Test plan
- Write 0x41, then 0x42 to 0x30000 with `tx_ready`=1 → `tx_data` 0x41 then 0x42 on consecutive cycles; `tx_valid` low afterward; `tx_count`=2 (with the macro).
- Write 0x00 to 0x30000 → no `tx_valid`; count unchanged.
- `tx_ready`=0; write 14 bytes with `DEPTH`=16, `FULL_MARGIN`=2 → `io_buffer_full` rises the cycle after the 14th write. Writes 15–16 are accepted. A 17th write sets `overflow`=1 and that byte never appears.
- Queue 0x61, 0x62, write 0x30004, hold `tx_ready` low 3 cycles then high → bytes 0x61, 0x62, 0x00 in that order; `prog_stop`=1 the cycle after the NUL handshake. A later write of 0x63 produces no output.
- Pull `rst_in` low while in SEND_NUL → `tx_valid`=0 and `prog_stop`=0 immediately. After release, a write of 0x5A is transmitted normally.
- Hold `rdy_in`=0 during a 0x30000 write of 0x33 → ignored. Meanwhile a queued byte still drains on `tx_ready`.
